// File: rtl/adc_frame_buffer.sv
// Groups the ADC controller's per-channel sample stream into multi-channel frames and
// buffers them in a first-word-fall-through FIFO with overflow and resync detection.
module adc_frame_buffer #(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_CHANNELS = 6,
  parameter int FIFO_DEPTH   = 8,
  parameter int GAP_CYCLES   = 8
) (
  input  logic                               clk,
  input  logic                               sresetn,
  input  logic [DATA_WIDTH-1:0]              in_data,
  input  logic                               in_valid,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] m_frame,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic [$clog2(FIFO_DEPTH):0]        fill_level,
  output logic                               overflow,
  input  logic                               clear_overflow,
  output logic [15:0]                        drop_count,
  output logic                               frame_error
);

  localparam int FW    = NUM_CHANNELS * DATA_WIDTH;
  localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CHANNELS - 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [CH_W-1:0]  ch_q, ch_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             resync, complete, pop, push_ok, drop;
  logic [FW-1:0]    frame_in;

  logic [FW-1:0]    mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [FW-1:0]    head_q, head_d;
  logic             ov_q, ov_d, err_q;
  logic [15:0]      dc_q, dc_d;

  always_comb begin
    resync   = in_valid && (gap_q == GAP_MAX) && (ch_q != '0);
    complete = in_valid && !resync && (ch_q == LAST_CH);

    ch_d = ch_q;
    if (resync)
      ch_d = CH_W'(1);
    else if (complete)
      ch_d = '0;
    else if (in_valid)
      ch_d = ch_q + 1'b1;

    if (in_valid)
      gap_d = '0;
    else if (gap_q == GAP_MAX)
      gap_d = gap_q;
    else
      gap_d = gap_q + 1'b1;
  end

  // On a resync the incoming sample becomes channel 0 of a fresh frame.
  for (genvar gi = 0; gi < NUM_CHANNELS - 1; gi++) begin : g_slot
    logic [DATA_WIDTH-1:0] slot_q;
    always_ff @(posedge clk or negedge sresetn) begin
      if (!sresetn)
        slot_q <= '0;
      else if (in_valid && (resync ? (gi == 0) : (ch_q == CH_W'(gi))))
        slot_q <= in_data;
    end
    assign frame_in[gi*DATA_WIDTH +: DATA_WIDTH] = slot_q;
  end
  assign frame_in[FW-1 -: DATA_WIDTH] = in_data;

  always_comb begin
    pop     = (cnt_q != '0) && m_ready;
    push_ok = complete && ((cnt_q != DEPTH_C) || pop);
    drop    = complete && !push_ok;
    rd_d    = pop ? rd_q + 1'b1 : rd_q;
    wr_d    = push_ok ? wr_q + 1'b1 : wr_q;
    cnt_d   = cnt_q + CNT_W'(push_ok) - CNT_W'(pop);

    // The new frame bypasses memory when it lands at the head of an otherwise empty FIFO.
    head_d = head_q;
    if (push_ok && ((cnt_q - CNT_W'(pop)) == '0))
      head_d = frame_in;
    else if (cnt_d != '0)
      head_d = mem_q[rd_d];

    ov_d = ov_q;
    dc_d = dc_q;
    if (drop) begin
      ov_d = 1'b1;
      if (clear_overflow)
        dc_d = 16'd1;
      else if (dc_q != 16'hFFFF)
        dc_d = dc_q + 16'd1;
    end else if (clear_overflow) begin
      ov_d = 1'b0;
      dc_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem_q[wr_q] <= frame_in;
  end

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      ch_q   <= '0;
      gap_q  <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      head_q <= '0;
      ov_q   <= 1'b0;
      dc_q   <= '0;
      err_q  <= 1'b0;
    end else begin
      ch_q   <= ch_d;
      gap_q  <= gap_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
      ov_q   <= ov_d;
      dc_q   <= dc_d;
      err_q  <= resync;
    end
  end

  assign m_frame     = head_q;
  assign m_valid     = (cnt_q != '0);
  assign fill_level  = cnt_q;
  assign overflow    = ov_q;
  assign drop_count  = dc_q;
  assign frame_error = err_q;

endmodule

// File: tb/tb_adc_frame_buffer.sv
// Directed bench for adc_frame_buffer: a queue-based frame model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_adc_frame_buffer;

  localparam int DW    = 16;
  localparam int NC    = 6;
  localparam int DEPTH = 8;
  localparam int GAP   = 8;
  localparam int FW    = NC * DW;

  logic          clk = 1'b0;
  logic          sresetn = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic [FW-1:0] m_frame;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [3:0]    fill_level;
  logic          overflow;
  logic          clear_overflow = 1'b0;
  logic [15:0]   drop_count;
  logic          frame_error;

  adc_frame_buffer #(.DATA_WIDTH(DW), .NUM_CHANNELS(NC), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .sresetn(sresetn), .in_data(in_data), .in_valid(in_valid),
    .m_frame(m_frame), .m_valid(m_valid), .m_ready(m_ready), .fill_level(fill_level),
    .overflow(overflow), .clear_overflow(clear_overflow), .drop_count(drop_count),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int err_pulses = 0;

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frames as a queue, the partial frame as a list of samples.
  logic [FW-1:0] mq[$];
  logic [DW-1:0] part[$];
  int            idle = 0;
  bit            m_ov = 0;
  int            m_dc = 0;
  bit            m_err = 0;
  bit            popm, done, dropm;
  logic [FW-1:0] fr;

  initial forever begin
    @(posedge clk or negedge sresetn);
    if (!sresetn) begin
      mq.delete(); part.delete();
      idle = 0; m_ov = 0; m_dc = 0; m_err = 0;
    end else begin
      popm = (mq.size() != 0) && m_ready;
      done = 0; dropm = 0; m_err = 0;
      if (in_valid) begin
        if (idle >= GAP && part.size() != 0) begin
          m_err = 1;
          part.delete();
        end
        part.push_back(in_data);
        if (part.size() == NC) begin
          for (int i = 0; i < NC; i++) fr[i*DW +: DW] = part[i];
          part.delete();
          done = 1;
        end
        idle = 0;
      end else if (idle < GAP) begin
        idle++;
      end
      if (popm) void'(mq.pop_front());
      if (done) begin
        if (mq.size() < DEPTH) mq.push_back(fr);
        else dropm = 1;
      end
      if (dropm) begin
        m_ov = 1;
        m_dc = clear_overflow ? 1 : ((m_dc < 65535) ? m_dc + 1 : m_dc);
      end else if (clear_overflow) begin
        m_ov = 0;
        m_dc = 0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (frame_error) err_pulses++;
    check("m_valid", m_valid, mq.size() != 0);
    check("fill_level", fill_level, mq.size());
    if (mq.size() != 0) check("m_frame", m_frame, mq[0]);
    check("overflow", overflow, m_ov);
    check("drop_count", drop_count, m_dc);
    check("frame_error", frame_error, m_err);
  end

  task automatic tick(input logic v, input logic [DW-1:0] d);
    @(negedge clk);
    #2;
    in_valid = v;
    in_data = d;
    clear_overflow = 1'b0;
  endtask

  function automatic logic [DW-1:0] fdat(input int f, input int c);
    return DW'(f * 256 + c);
  endfunction

  task automatic send_frame(input int f);
    for (int c = 0; c < NC; c++) tick(1'b1, fdat(f, c));
  endtask

  initial begin
    int e0;
    repeat (3) @(negedge clk);
    #2 sresetn = 1'b1;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_frame", m_frame, 0);
    check("rst_fill", fill_level, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drop_count", drop_count, 0);
    check("rst_frame_error", frame_error, 0);

    // Single frame, samples three cycles apart.
    m_ready = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick(1'b1, DW'(i));
      if (i < 6) begin tick(1'b0, '0); tick(1'b0, '0); end
    end
    tick(1'b0, '0);
    check("t1_valid", m_valid, 1);
    check("t1_frame", m_frame, 96'h0006_0005_0004_0003_0002_0001);
    check("t1_fill", fill_level, 1);
    tick(1'b0, '0);
    check("t1_fill_after_pop", fill_level, 0);
    check("t1_no_error", err_pulses, 0);
    $display("T1 single frame done checks=%0d", checks);

    // Overflow with consumer stalled, then drain.
    m_ready = 1'b0;
    for (int f = 1; f <= 10; f++) send_frame(f);
    tick(1'b0, '0);
    check("t2_fill", fill_level, 8);
    check("t2_overflow", overflow, 1);
    check("t2_drop_count", drop_count, 2);
    check("t2_head", m_frame, 96'h0105_0104_0103_0102_0101_0100);
    m_ready = 1'b1;
    repeat (7) tick(1'b0, '0);
    check("t2_last_frame", m_frame, 96'h0805_0804_0803_0802_0801_0800);
    tick(1'b0, '0);
    check("t2_drained", fill_level, 0);
    $display("T2 overflow and drain done checks=%0d", checks);

    // Gap resync discards a partial frame.
    e0 = err_pulses;
    tick(1'b1, 16'h0011); tick(1'b1, 16'h0012); tick(1'b1, 16'h0013);
    repeat (12) tick(1'b0, '0);
    for (int i = 0; i < 6; i++) tick(1'b1, DW'(16'hA0 + i));
    tick(1'b0, '0);
    check("t3_frame", m_frame, 96'h00A5_00A4_00A3_00A2_00A1_00A0);
    check("t3_valid", m_valid, 1);
    check("t3_error_pulses", err_pulses - e0, 1);
    tick(1'b0, '0);
    $display("T3 gap resync done checks=%0d", checks);

    // Push and pop at full capacity in the same cycle.
    clear_overflow = 1'b1;
    tick(1'b0, '0);
    check("t4_cleared_ov", overflow, 0);
    check("t4_cleared_dc", drop_count, 0);
    m_ready = 1'b0;
    for (int f = 11; f <= 18; f++) send_frame(f);
    for (int c = 0; c < 5; c++) tick(1'b1, fdat(19, c));
    tick(1'b1, fdat(19, 5));
    m_ready = 1'b1;
    tick(1'b0, '0);
    m_ready = 1'b0;
    check("t4_fill", fill_level, 8);
    check("t4_overflow", overflow, 0);
    check("t4_head", m_frame, 96'h0C05_0C04_0C03_0C02_0C01_0C00);
    $display("T4 full push+pop done checks=%0d", checks);

    // Clear coincident with a drop: the drop wins.
    for (int f = 20; f <= 24; f++) send_frame(f);
    tick(1'b0, '0);
    check("t6_overflow", overflow, 1);
    check("t6_drop5", drop_count, 5);
    for (int c = 0; c < 5; c++) tick(1'b1, fdat(25, c));
    tick(1'b1, fdat(25, 5));
    clear_overflow = 1'b1;
    tick(1'b0, '0);
    check("t6_overflow_kept", overflow, 1);
    check("t6_drop_restart", drop_count, 1);
    $display("T6 clear vs drop done checks=%0d", checks);

    // Asynchronous reset mid-frame with three frames stored.
    m_ready = 1'b1;
    repeat (5) tick(1'b0, '0);
    m_ready = 1'b0;
    check("t5_fill3", fill_level, 3);
    tick(1'b1, 16'h7777);
    tick(1'b1, 16'h7778);
    @(negedge clk);
    #3 sresetn = 1'b0;
    in_valid = 1'b0;
    #1;
    check("t5_async_valid", m_valid, 0);
    check("t5_async_fill", fill_level, 0);
    repeat (2) @(negedge clk);
    #2 sresetn = 1'b1;
    for (int i = 0; i < 6; i++) tick(1'b1, DW'(16'hB0 + i));
    tick(1'b0, '0);
    check("t5_frame", m_frame, 96'h00B5_00B4_00B3_00B2_00B1_00B0);
    check("t5_fill1", fill_level, 1);
    m_ready = 1'b1;
    tick(1'b0, '0);
    check("t5_drained", fill_level, 0);
    $display("T5 async reset done checks=%0d", checks);

    tick(1'b0, '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_frame_buffer.md
Name: adc_frame_buffer

Overview:
- Sits directly downstream of the ADS8528 controller.
- Consumes its single-word sample stream (in_data/in_valid, one sample per channel, sequential, no backpressure).
- Groups consecutive samples into multi-channel frames, one simultaneous conversion per frame, and buffers frames in a FIFO.
- Presents frames to the localization datapath on a valid/ready handshake, and detects overflow and broken frames because the upstream stage cannot be stalled.

Parameters:
DATA_WIDTH, 16, bits per ADC sample
NUM_CHANNELS, 6, samples per frame (channel 0 first)
FIFO_DEPTH, 8, frame capacity of FIFO; power of two, >= 2
GAP_CYCLES, 8, idle cycles after which the next sample is treated as channel 0

Ports:
clk  input  1  system clock
sresetn  input  1  asynchronous active-low reset
in_data  input  DATA_WIDTH  sample from ADC controller
in_valid  input  1  in_data valid this cycle (single-cycle pulses)
m_frame  output  NUM_CHANNELS*DATA_WIDTH  frame; channel i at bits [i*DATA_WIDTH +: DATA_WIDTH]
m_valid  output  1  m_frame valid
m_ready  input  1  consumer accepts frame when m_valid && m_ready
fill_level  output  $clog2(FIFO_DEPTH)+1  frames currently stored
overflow  output  1  sticky: a completed frame was dropped
clear_overflow  input  1  synchronous clear of overflow and drop_count
drop_count  output  16  frames dropped, saturating at 16'hFFFF
frame_error  output  1  one-cycle pulse: partial frame discarded

Behaviour:
- Reset (async assert, sync release): FIFO empty, m_valid=0, m_frame=0, fill_level=0, overflow=0, drop_count=0, frame_error=0, channel index=0, gap counter=0.
- All state changes occur on posedge clk.
- Assembly:
  - Channel index ch (0..NUM_CHANNELS-1).
  - On in_valid, in_data is stored in slot ch and ch increments.
  - On the sample with ch==NUM_CHANNELS-1, the completed frame (stored slots plus the current in_data) is pushed into the FIFO at that same edge, and ch wraps to 0.
- Gap resync:
  - Gap counter clears on in_valid and otherwise increments, saturating at GAP_CYCLES.
  - If in_valid arrives with gap counter == GAP_CYCLES and ch != 0:
    - The partial frame is discarded.
    - The incoming sample is stored as channel 0 and ch becomes 1.
    - frame_error pulses high for exactly one cycle, in the cycle after that edge.
  - If ch==0, no error is raised.
- Push when full:
  - If the FIFO is full and no pop occurs in the same cycle, the frame is dropped.
  - overflow sets and drop_count increments (saturating). FIFO contents are unchanged.
- Push and pop in the same cycle:
  - Allowed at any fill level, including full: the push is accepted and fill_level is unchanged.
- Output:
  - First-word-fall-through. m_valid = (fill_level != 0); m_frame = head entry, registered.
  - Latency: a frame completed at edge k is visible with m_valid=1 in the cycle after edge k when the FIFO was empty.
  - Pop occurs on m_valid && m_ready.
  - m_frame/m_valid hold stable while m_valid && !m_ready.
- Pointers: read and write pointers wrap modulo FIFO_DEPTH; fill_level ranges 0..FIFO_DEPTH.
- clear_overflow:
  - Clears overflow and drop_count on the next edge.
  - If a drop occurs in the same cycle, the drop wins: overflow=1, drop_count=1.
- Mid-operation reset: the partial frame and all FIFO contents are discarded. After release, the first sample is channel 0.
- Sample ordering is preserved across frames and frames are never reordered.
- Any in_valid held for consecutive cycles is treated as consecutive samples.

Test Plan:
1. After reset, drive 6 samples 16'h0001..16'h0006 three cycles apart with m_ready=1 -> one cycle after the 6th sample, m_valid=1 and m_frame=96'h0006_0005_0004_0003_0002_0001; the frame pops next cycle, fill_level returns to 0, frame_error never asserts.
2. Hold m_ready=0 and stream 10 complete frames -> fill_level saturates at 8, overflow=1, drop_count=2; draining yields frames 1..8 in order.
3. Send 3 samples, idle 12 cycles, then send 6 samples 16'hA0..16'hA5 -> frame_error pulses once; the emitted frame is 16'hA0..16'hA5 with 16'hA0 in channel 0.
4. With FIFO full and m_ready=1, complete a frame in the same cycle as a pop -> no drop, fill_level stays 8, overflow stays 0.
5. Assert sresetn low asynchronously mid-frame with 3 stored frames -> m_valid and fill_level go 0 immediately without waiting for a clock edge; post-release the next 6 samples form a correct frame.
6. With overflow=1 and drop_count=5, pulse clear_overflow coincident with another drop -> overflow=1, drop_count=1.
